// File: rtl/ram_arbiter.sv
// Two-requester (I read-only, D read/write) arbiter for a single RAM port with bus timeout.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise D-side has fixed priority.
module ram_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        memREN,
    output logic        memWEN,
    output logic [31:0] memaddr,
    output logic [31:0] memstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        arb_err,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      lat_addr, lat_store;
    logic             lat_ren, lat_wen;
    logic             ireq, dreq, pick_d, granted, acked, tmo, finish;

    assign ireq = iREN;
    assign dreq = dREN | dWEN;

`ifdef RAM_ARB_RR_EN
    // last_d == 0 means the I-side was granted last (reset value).
    logic last_d;
    assign pick_d = dreq && (!ireq || !last_d);

    always_ff @(posedge CLK) begin
        if (RST)
            last_d <= 1'b0;
        else if (state == IDLE && (ireq || dreq))
            last_d <= pick_d;
    end
`else
    assign pick_d = dreq;
`endif

    assign granted = (state != IDLE);
    assign acked   = granted && (ramstate == RAM_ACCESS || ramstate == RAM_ERROR);
    assign tmo     = granted && !acked && TIMEOUT_EN && (cnt == CNT_LAST);
    assign finish  = acked || tmo;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_d)
                    state_nx = DGRANT;
                else if (ireq)
                    state_nx = IGRANT;
            end
            IGRANT, DGRANT: begin
                if (finish)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latches load only while idle, so requester changes during a grant are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_addr  <= '0;
            lat_store <= '0;
            lat_ren   <= 1'b0;
            lat_wen   <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_ren   <= dREN & ~dWEN;
                lat_wen   <= dWEN;
            end else if (ireq) begin
                lat_addr  <= iaddr;
                lat_store <= '0;
                lat_ren   <= 1'b1;
                lat_wen   <= 1'b0;
            end
        end
    end

    // Counts granted cycles; saturates so a disabled timeout never wraps.
    always_ff @(posedge CLK) begin
        if (RST || finish || state == IDLE)
            cnt <= '0;
        else if (cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        memREN    = granted & lat_ren;
        memWEN    = granted & lat_wen;
        memaddr   = granted ? lat_addr  : '0;
        memstore  = granted ? lat_store : '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        arb_err   = granted && (ramstate == RAM_ERROR || tmo);
        dbg_state = state;
        if (state == IGRANT && finish) begin
            iwait = 1'b0;
            iload = acked ? ramload : '0;
        end
        if (state == DGRANT && finish) begin
            dwait = 1'b0;
            dload = acked ? ramload : '0;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_ram_arbiter;

    localparam int TO = 4;
    localparam int CW = 8;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = BUSY;
    logic        iwait, dwait, memREN, memWEN, arb_err;
    logic [31:0] iload, dload, memaddr, memstore;
    logic [1:0]  dbg_state;

    always #5 CLK = ~CLK;

    ram_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
        .ramstate(ramstate), .ramload(ramload), .arb_err(arb_err),
        .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one in-flight request record plus arbitration history.
    bit          mvalid = 0, busy = 0, m_side_d = 0, m_rd = 0, m_wr = 0, last_d = 0;
    logic [31:0] m_addr = '0, m_data = '0;
    int          age = 0;
    logic [0:0]  exp_q[$];
    bit          sb_on = 0;

    always @(negedge CLK) begin
        bit ack, tmo, fin, win;
        if (mvalid) begin
            ack = busy && (ramstate == ACCESS || ramstate == ERROR);
            tmo = busy && !ack && (age + 1 == TO);
            fin = ack || tmo;
            chk("m_memREN", memREN, busy & m_rd);
            chk("m_memWEN", memWEN, busy & m_wr);
            chk("m_memaddr", memaddr, busy ? m_addr : 32'h0);
            if (!busy || m_side_d)
                chk("m_memstore", memstore, busy ? m_data : 32'h0);
            chk("m_iwait", iwait, !(busy && !m_side_d && fin));
            chk("m_dwait", dwait, !(busy && m_side_d && fin));
            chk("m_iload", iload, (busy && !m_side_d && ack) ? ramload : 32'h0);
            chk("m_dload", dload, (busy && m_side_d && ack) ? ramload : 32'h0);
            chk("m_arb_err", arb_err, busy && (ramstate == ERROR || tmo));
            if (sb_on && (!dwait || !iwait) && exp_q.size() > 0)
                chk("grant_order", {31'h0, !dwait}, {31'h0, exp_q.pop_front()});
            if (RST) begin
                busy = 0; age = 0; last_d = 0;
            end else if (busy) begin
                if (fin) busy = 0;
                else age++;
            end else if (iREN || dREN || dWEN) begin
`ifdef RAM_ARB_RR_EN
                win = (dREN || dWEN) && (!iREN || !last_d);
`else
                win = dREN || dWEN;
`endif
                busy = 1; age = 0; m_side_d = win; last_d = win;
                if (win) begin
                    m_addr = daddr; m_data = dstore; m_wr = dWEN; m_rd = dREN & ~dWEN;
                end else begin
                    m_addr = iaddr; m_data = '0; m_wr = 0; m_rd = 1;
                end
            end
        end else if (RST) begin
            busy = 0; age = 0; last_d = 0; mvalid = 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit i_done, d_done;
        int op, r;

        // reset
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_memREN", memREN, 0);
        chk("rst_memWEN", memWEN, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_memstore", memstore, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_arb_err", arb_err, 0);
        chk("rst_state", dbg_state, 0);
        step();

        // I read, ACCESS in third granted cycle
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        @(negedge CLK); chk("ird_idle_memREN", memREN, 0); step();
        @(negedge CLK); chk("ird_g1_memREN", memREN, 1); chk("ird_g1_memaddr", memaddr, 32'h40);
        chk("ird_g1_iwait", iwait, 1); step();
        @(negedge CLK); chk("ird_g2_iwait", iwait, 1); step();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        @(negedge CLK); chk("ird_g3_iwait", iwait, 0); chk("ird_g3_iload", iload, 32'hDEADBEEF); step();
        iREN = 0; ramstate = BUSY;
        @(negedge CLK); chk("ird_after_memREN", memREN, 0); chk("ird_after_iwait", iwait, 1); step();

        // D write
        dWEN = 1; daddr = 32'h100; dstore = 32'h12345678;
        @(negedge CLK); step();
        @(negedge CLK); chk("dwr_g1_memWEN", memWEN, 1); chk("dwr_g1_memstore", memstore, 32'h12345678);
        chk("dwr_g1_memREN", memREN, 0); chk("dwr_g1_dwait", dwait, 1); step();
        ramstate = ACCESS;
        @(negedge CLK); chk("dwr_g2_dwait", dwait, 0); chk("dwr_g2_memREN", memREN, 0); step();
        dWEN = 0; ramstate = BUSY;
        @(negedge CLK); chk("dwr_after_memWEN", memWEN, 0); chk("dwr_after_dwait", dwait, 1); step();

        // timeout in 4th granted cycle
        dREN = 1; daddr = 32'h80; ramstate = BUSY; ramload = 32'hA5A5A5A5;
        @(negedge CLK); step();
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK); chk("tmo_wait_dwait", dwait, 1); chk("tmo_wait_err", arb_err, 0); step();
        end
        @(negedge CLK); chk("tmo_dwait", dwait, 0); chk("tmo_dload", dload, 0); chk("tmo_err", arb_err, 1); step();
        dREN = 0;
        @(negedge CLK); chk("tmo_idle_state", dbg_state, 0); chk("tmo_idle_memREN", memREN, 0);
        chk("tmo_idle_err", arb_err, 0); step();

        // ERROR completion, then a normal D read
        iREN = 1; iaddr = 32'h44; ramstate = BUSY;
        @(negedge CLK); step();
        @(negedge CLK); chk("err_g1_iwait", iwait, 1); step();
        ramstate = ERROR; ramload = 32'h0BADF00D;
        @(negedge CLK); chk("err_iwait", iwait, 0); chk("err_iload", iload, 32'h0BADF00D); chk("err_pulse", arb_err, 1); step();
        iREN = 0; dREN = 1; daddr = 32'h200; ramstate = BUSY;
        @(negedge CLK); chk("err_next_pulse", arb_err, 0); chk("err_next_memREN", memREN, 0); step();
        ramstate = ACCESS; ramload = 32'h55;
        @(negedge CLK); chk("err_d_memREN", memREN, 1); chk("err_d_memaddr", memaddr, 32'h200);
        chk("err_d_dwait", dwait, 0); chk("err_d_dload", dload, 32'h55); step();
        dREN = 0; ramstate = BUSY;
        @(negedge CLK); step();

        // reset in the second granted cycle
        iREN = 1; iaddr = 32'h48;
        @(negedge CLK); step();
        @(negedge CLK); chk("rmg_g1_memREN", memREN, 1); step();
        RST = 1;
        @(negedge CLK); step();
        RST = 0; iREN = 0; dREN = 1; daddr = 32'h300;
        @(negedge CLK); chk("rmg_memREN", memREN, 0); chk("rmg_memWEN", memWEN, 0); chk("rmg_iwait", iwait, 1);
        chk("rmg_dwait", dwait, 1); chk("rmg_err", arb_err, 0); step();
        ramstate = ACCESS;
        @(negedge CLK); chk("rmg_new_memREN", memREN, 1); chk("rmg_new_memaddr", memaddr, 32'h300);
        chk("rmg_new_dwait", dwait, 0); step();
        dREN = 0; ramstate = BUSY;
        @(negedge CLK); step();

        // contention: both sides request continuously, four transactions
        RST = 1; step(); RST = 0;
`ifdef RAM_ARB_RR_EN
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        sb_on = 1; iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h10; daddr = 32'h20; ramstate = ACCESS;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();
        sb_on = 0;
        chk("contention_done", exp_q.size(), 0);
        iREN = 0; dREN = 0; ramstate = BUSY;
        step(); step();

        // randomized traffic with well-behaved requesters
        repeat (3000) begin
            @(negedge CLK);
            i_done = !iwait;
            d_done = !dwait;
            @(posedge CLK);
            #1;
            if (!iREN || i_done) begin
                iREN = ($urandom_range(0, 2) == 0);
                iaddr = $urandom;
            end
            if (!(dREN || dWEN) || d_done) begin
                op = $urandom_range(0, 5);
                dREN = (op == 1 || op == 3);
                dWEN = (op == 2 || op == 3);
                daddr = $urandom;
                dstore = $urandom;
            end
            r = $urandom_range(0, 19);
            ramstate = (r < 6) ? ACCESS : (r == 6) ? ERROR : (r == 7) ? FREE : BUSY;
            ramload = $urandom;
            RST = ($urandom_range(0, 299) == 0);
        end
        RST = 0; iREN = 0; dREN = 0; dWEN = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
